// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1101 serial pattern detector: state encoding and pattern constants.
package seq_det_pkg;

  typedef logic [2:0] state_t;

  // Explicit encodings keep the 3-bit register free to hold the unused codes 5..7.
  localparam state_t S0 = 3'b000;
  localparam state_t S1 = 3'b001;
  localparam state_t S2 = 3'b010;
  localparam state_t S3 = 3'b011;
  localparam state_t S4 = 3'b100;

  localparam logic [3:0] PATTERN     = 4'b1101;
  localparam int         PATTERN_LEN = 4;

endpackage

// File: rtl/seq_det_ea.sv
// Moore FSM that strobes dout for one cycle each time the last four sampled din bits are 1101.
module seq_det_ea
  import seq_det_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout
);

  state_t r_state;
  state_t w_next;

  always_comb begin
    w_next = S0;
    case (r_state)
      S0: w_next = din ? S1 : S0;
      S1: w_next = din ? S2 : S0;
      S2: w_next = din ? S2 : S3;
      S3: w_next = din ? S4 : S0;
      // After a hit, the trailing "1" can seed the next match as "11" only when overlapping.
      S4: w_next = din ? (OVERLAP ? S2 : S1) : S0;
      default: w_next = S0;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S0;
    else      r_state <= w_next;
  end

  // Decoded from the state register only, so reset clears it without a clock edge.
  assign dout = (r_state == S4);

endmodule

// File: tb/tb_seq_det_ea.sv
// Directed bench for seq_det_ea, driving an overlapping and a non-overlapping instance in parallel.
module tb_seq_det_ea;

  logic clk;
  logic clr;
  logic din;
  logic dout_ov;
  logic dout_no;

  int n_vec;
  int n_err;

  seq_det_ea #(.OVERLAP(1'b1)) dut_ov (
    .clk  (clk),
    .clr  (clr),
    .din  (din),
    .dout (dout_ov)
  );

  seq_det_ea #(.OVERLAP(1'b0)) dut_no (
    .clk  (clk),
    .clr  (clr),
    .din  (din),
    .dout (dout_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Change din on the falling edge, then sample outputs 1 time unit after the rising edge.
  task automatic clk_bit(input logic b);
    @(negedge clk);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    din = 1'b0;
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    din = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      din = ~din;
      @(posedge clk);
      #1;
      n_vec++;
      if (dout_ov !== 1'b0 || dout_no !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold edge %0d: dout_ov=%b dout_no=%b, required 0/0", i, dout_ov, dout_no);
      end
    end
    @(negedge clk);
    clr = 1'b1;
    // Reach S4, then pull clr low mid-cycle and check dout drops before the next edge.
    clk_bit(1'b1);
    clk_bit(1'b1);
    clk_bit(1'b0);
    clk_bit(1'b1);
    n_vec++;
    if (dout_ov !== 1'b1 || dout_no !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre_async: dout_ov=%b dout_no=%b, required 1/1", dout_ov, dout_no);
    end
    #2;
    clr = 1'b0;
    #1;
    n_vec++;
    if (dout_ov !== 1'b0 || dout_no !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: dout_ov=%b dout_no=%b, required 0/0", dout_ov, dout_no);
    end
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_basic_match();
    logic [4:0] seq;
    logic [4:0] exp;
    seq = 5'b11010;
    exp = 5'b00010;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      clk_bit(seq[4-i]);
      n_vec++;
      if (dout_ov !== exp[4-i] || dout_no !== exp[4-i]) begin
        n_err++;
        $display("FAIL basic edge %0d: dout_ov=%b dout_no=%b, required %b", i + 1, dout_ov, dout_no, exp[4-i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] seq;
    logic [6:0] exp_ov;
    logic [6:0] exp_no;
    seq    = 7'b1101101;
    exp_ov = 7'b0001001;
    exp_no = 7'b0001000;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      clk_bit(seq[6-i]);
      n_vec++;
      if (dout_ov !== exp_ov[6-i]) begin
        n_err++;
        $display("FAIL overlap edge %0d: dout=%b, required %b", i + 1, dout_ov, exp_ov[6-i]);
      end
      n_vec++;
      if (dout_no !== exp_no[6-i]) begin
        n_err++;
        $display("FAIL non_overlap edge %0d: dout=%b, required %b", i + 1, dout_no, exp_no[6-i]);
      end
    end
  endtask

  task automatic test_long_ones();
    logic [5:0] seq;
    logic [5:0] exp;
    seq = 6'b111101;
    exp = 6'b000001;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      clk_bit(seq[5-i]);
      n_vec++;
      if (dout_ov !== exp[5-i] || dout_no !== exp[5-i]) begin
        n_err++;
        $display("FAIL long_ones edge %0d: dout_ov=%b dout_no=%b, required %b", i + 1, dout_ov, dout_no, exp[5-i]);
      end
    end
  endtask

  task automatic test_near_miss();
    logic [7:0] seq;
    logic [7:0] exp;
    seq = 8'b11001101;
    exp = 8'b00000001;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      clk_bit(seq[7-i]);
      n_vec++;
      if (dout_ov !== exp[7-i] || dout_no !== exp[7-i]) begin
        n_err++;
        $display("FAIL near_miss edge %0d: dout_ov=%b dout_no=%b, required %b", i + 1, dout_ov, dout_no, exp[7-i]);
      end
    end
  endtask

  task automatic test_interrupted();
    do_reset();
    clk_bit(1'b1);
    clk_bit(1'b1);
    clk_bit(1'b0);
    do_reset();
    clk_bit(1'b1);
    n_vec++;
    if (dout_ov !== 1'b0 || dout_no !== 1'b0) begin
      n_err++;
      $display("FAIL interrupted: dout_ov=%b dout_no=%b, required 0/0", dout_ov, dout_no);
    end
    clk_bit(1'b0);
    n_vec++;
    if (dout_ov !== 1'b0 || dout_no !== 1'b0) begin
      n_err++;
      $display("FAIL interrupted_tail: dout_ov=%b dout_no=%b, required 0/0", dout_ov, dout_no);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clr   = 1'b0;
    din   = 1'b0;
    test_reset();
    test_basic_match();
    test_back_to_back();
    test_long_ones();
    test_near_miss();
    test_interrupted();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
